// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one KCPSM3-style ALU between NUM_REQ requesters,
// keeping a private carry/zero context per requester so carry chains survive interleaving.
module alu_share_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int OPERAND_WIDTH = 8,
  parameter int OP_W          = 10,
  parameter int ALU_LATENCY   = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*OP_W-1:0]          req_op,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_b,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic [OPERAND_WIDTH-1:0]         rsp_result,
  output logic                             rsp_zero,
  output logic                             rsp_carry,
  output logic [OP_W-1:0]                  alu_op,
  output logic [OPERAND_WIDTH-1:0]         alu_a,
  output logic [OPERAND_WIDTH-1:0]         alu_b,
  output logic                             alu_carry_in,
  input  logic [OPERAND_WIDTH-1:0]         alu_result,
  input  logic                             alu_zero,
  input  logic                             alu_carry
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                     state, state_next;
  logic [ID_W-1:0]            last_grant;
  logic [ID_W-1:0]            cur_id;
  logic [ID_W-1:0]            grant_idx;
  logic                       grant_found;
  logic [OP_W-1:0]            op_sel;
  logic [OPERAND_WIDTH-1:0]   a_sel;
  logic [OPERAND_WIDTH-1:0]   b_sel;
  logic                       cin_sel;
  logic [CNT_W-1:0]           cnt;
  logic [NUM_REQ-1:0]         carry_ctx;
  logic [NUM_REQ-1:0]         zero_ctx;

  // Indices above last_grant win first; if none is valid, wrap to the lowest valid index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (ID_W'(i) > last_grant)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
  end

  always_comb begin
    op_sel  = '0;
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        op_sel  = req_op[i*OP_W +: OP_W];
        a_sel   = req_a[i*OPERAND_WIDTH +: OPERAND_WIDTH];
        b_sel   = req_b[i*OPERAND_WIDTH +: OPERAND_WIDTH];
        cin_sel = carry_ctx[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Accept pulses are only ever raised in IDLE and are held low while reset is asserted.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    unique case (state)
      S_IDLE: begin
        if (grant_found) begin
          state_next           = S_ISSUE;
          req_ready[grant_idx] = reset_n;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (cnt == '0) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant   <= ID_W'(NUM_REQ - 1);
      cur_id       <= '0;
      cnt          <= '0;
      carry_ctx    <= '0;
      zero_ctx     <= '0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_carry_in <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant_found) begin
            alu_op       <= op_sel;
            alu_a        <= a_sel;
            alu_b        <= b_sel;
            alu_carry_in <= cin_sel;
            cur_id       <= grant_idx;
            last_grant   <= grant_idx;
          end
        end
        S_ISSUE: cnt <= CNT_W'(ALU_LATENCY - 1);
        S_WAIT: begin
          if (cnt == '0) begin
            rsp_valid         <= 1'b1;
            rsp_id            <= cur_id;
            rsp_result        <= alu_result;
            rsp_zero          <= alu_zero;
            rsp_carry         <= alu_carry;
            carry_ctx[cur_id] <= alu_carry;
            zero_ctx[cur_id]  <= alu_zero;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: a behavioural ALU plus round-robin reference predicts every grant and response.
module tb_alu_share_arbiter #(
  parameter int LAT = 1
);

  localparam int NUM_REQ = 2;
  localparam int OW      = 8;
  localparam int OP_W    = 10;
  localparam int ID_W    = $clog2(NUM_REQ);

  localparam logic [5:0] C_ADD   = 6'h18;
  localparam logic [5:0] C_ADDCY = 6'h1A;
  localparam logic [5:0] C_SUB   = 6'h1C;
  localparam logic [5:0] C_SUBCY = 6'h1E;
  localparam logic [5:0] C_AND   = 6'h0A;
  localparam logic [5:0] C_OR    = 6'h0C;
  localparam logic [5:0] C_XOR   = 6'h0E;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [OW-1:0]   a;
    logic [OW-1:0]   b;
  } op_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [OW-1:0]   res;
    logic            zero;
    logic            carry;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OP_W-1:0] req_op;
  logic [NUM_REQ*OW-1:0]   req_a;
  logic [NUM_REQ*OW-1:0]   req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [OW-1:0]           rsp_result;
  logic                    rsp_zero;
  logic                    rsp_carry;
  logic [OP_W-1:0]         alu_op;
  logic [OW-1:0]           alu_a;
  logic [OW-1:0]           alu_b;
  logic                    alu_carry_in;
  logic [OW-1:0]           alu_result;
  logic                    alu_zero;
  logic                    alu_carry;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .NUM_REQ(NUM_REQ), .OPERAND_WIDTH(OW), .OP_W(OP_W), .ALU_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry)
  );

  // Arithmetic meaning of each KCPSM3 operation; returns {carry, zero, result}.
  function automatic logic [9:0] alu_ref(input logic [OP_W-1:0] op, input logic [OW-1:0] a,
                                         input logic [OW-1:0] b, input logic cin);
    int         r;
    logic [7:0] res;
    logic       c;
    r = 0;
    c = 1'b0;
    case (op[9:4])
      C_ADD:   begin r = int'(a) + int'(b);            c = (r > 255); end
      C_ADDCY: begin r = int'(a) + int'(b) + int'(cin); c = (r > 255); end
      C_SUB:   begin r = int'(a) - int'(b);            c = (r < 0);   end
      C_SUBCY: begin r = int'(a) - int'(b) - int'(cin); c = (r < 0);   end
      C_AND:   r = int'(a & b);
      C_OR:    r = int'(a | b);
      C_XOR:   r = int'(a ^ b);
      default: r = int'(b);
    endcase
    res = 8'(r);
    return {c, (res == 8'h00), res};
  endfunction

  assign {alu_carry, alu_zero, alu_result} = alu_ref(alu_op, alu_a, alu_b, alu_carry_in);

  int                 vectors = 0;
  int                 mism = 0;
  int                 cyc = 0;
  int                 grant_cyc = 0;
  int                 rst_lo = 0;
  int                 drv_timeouts = 0;
  int                 timeouts_seen = 0;
  int                 m_last = NUM_REQ - 1;
  int                 mon_g;
  logic [NUM_REQ-1:0] m_carry = '0;
  logic [NUM_REQ-1:0] exp_ready;
  logic [NUM_REQ-1:0] acc_mask = '0;
  logic [NUM_REQ-1:0] last_acc = '0;
  logic               busy = 1'b0;
  logic               seen = 1'b0;
  logic               cin_chk = 1'b0;
  logic [OP_W+2*OW:0] exp_issue;
  logic [9:0]         exp_r;
  exp_t               sbq[$];
  op_t                pend[NUM_REQ][$];
  int                 hold_left = 0;
  logic               rand_rsp = 1'b0;

  function automatic void checkOutput(input string name, input logic [63:0] got,
                                      input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      mism++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endfunction

  // Monitor: predicts grants from the round-robin rule, checks the ALU issue and scoreboard responses.
  always @(negedge clk) begin
    cyc++;
    acc_mask = req_ready & req_valid;
    if (drv_timeouts != timeouts_seen) begin
      checkOutput("drain_timeout", 64'(drv_timeouts - timeouts_seen), 64'd0);
      timeouts_seen = drv_timeouts;
    end
    if (!reset_n) begin
      rst_lo++;
      checkOutput("ready_in_reset", 64'(req_ready), 64'd0);
      if (rst_lo >= 2) begin
        checkOutput("reset_outputs", 64'({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry,
                                          alu_op, alu_a, alu_b, alu_carry_in}), 64'd0);
      end
      sbq.delete();
      busy    = 1'b0;
      seen    = 1'b0;
      cin_chk = 1'b0;
      m_carry = '0;
      m_last  = NUM_REQ - 1;
    end else begin
      rst_lo = 0;
      if (cin_chk) begin
        checkOutput("alu_issue", 64'({alu_op, alu_a, alu_b, alu_carry_in}), 64'(exp_issue));
        cin_chk = 1'b0;
      end
      exp_ready = '0;
      mon_g     = -1;
      if (!busy && (|req_valid)) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (mon_g < 0 && req_valid[(m_last + k) % NUM_REQ]) mon_g = (m_last + k) % NUM_REQ;
        end
        exp_ready[mon_g] = 1'b1;
      end
      checkOutput("grant", 64'(req_ready), 64'(exp_ready));
      if (mon_g >= 0 && req_ready === exp_ready) begin
        exp_r     = alu_ref(req_op[mon_g*OP_W +: OP_W], req_a[mon_g*OW +: OW],
                            req_b[mon_g*OW +: OW], m_carry[mon_g]);
        exp_issue = {req_op[mon_g*OP_W +: OP_W], req_a[mon_g*OW +: OW],
                     req_b[mon_g*OW +: OW], m_carry[mon_g]};
        sbq.push_back('{id: ID_W'(mon_g), res: exp_r[7:0], zero: exp_r[8], carry: exp_r[9]});
        m_carry[mon_g] = exp_r[9];
        m_last    = mon_g;
        busy      = 1'b1;
        seen      = 1'b0;
        cin_chk   = 1'b1;
        grant_cyc = cyc;
      end
      if (sbq.size() == 0) begin
        checkOutput("spurious_rsp", 64'(rsp_valid), 64'd0);
      end else if (rsp_valid === 1'b1) begin
        checkOutput("rsp", 64'({rsp_id, rsp_result, rsp_zero, rsp_carry}), 64'(sbq[0]));
        if (!seen) begin
          checkOutput("latency", 64'(cyc - grant_cyc), 64'(2 + LAT));
          seen = 1'b1;
        end
        if (rsp_ready) begin
          void'(sbq.pop_front());
          busy = 1'b0;
          seen = 1'b0;
        end
      end else if (!seen && (cyc - grant_cyc) == 3 + LAT) begin
        checkOutput("rsp_valid_late", 64'(rsp_valid), 64'd1);
      end
    end
  end

  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend[i].size() > 0) begin
        req_valid[i]             = 1'b1;
        req_op[i*OP_W +: OP_W]   = pend[i][0].op;
        req_a[i*OW +: OW]        = pend[i][0].a;
        req_b[i*OW +: OW]        = pend[i][0].b;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    if (hold_left > 0 && rsp_valid) begin
      rsp_ready = 1'b0;
      hold_left--;
    end else if (rand_rsp) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      rsp_ready = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    last_acc = acc_mask;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_mask[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    end
    applyStimulus();
  endtask

  task automatic push_op(input int i, input logic [5:0] code, input logic [7:0] a, input logic [7:0] b);
    pend[i].push_back('{op: {code, 4'($urandom)}, a: a, b: b});
  endtask

  function automatic int pend_total();
    int n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += pend[i].size();
    return n;
  endfunction

  task automatic run_drain(input int max_cyc);
    int n = 0;
    applyStimulus();
    while ((pend_total() > 0 || sbq.size() > 0 || busy) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) drv_timeouts++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    applyStimulus();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
  endtask

  logic [5:0] codes[7];

  initial begin
    int n;
    codes     = '{C_ADD, C_ADDCY, C_SUB, C_SUBCY, C_AND, C_OR, C_XOR};
    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Single requester, simple add.
    do_reset();
    push_op(0, C_ADD, 8'h05, 8'h03);
    run_drain(40);

    // Both requesters busy: strict alternation.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_op(0, codes[$urandom_range(0, 6)], 8'($urandom), 8'($urandom));
      push_op(1, codes[$urandom_range(0, 6)], 8'($urandom), 8'($urandom));
    end
    run_drain(200);

    // Carry contexts stay private across interleaving.
    do_reset();
    push_op(0, C_ADD, 8'hFF, 8'h01);
    run_drain(40);
    push_op(1, C_ADDCY, 8'h00, 8'h00);
    run_drain(40);
    push_op(0, C_ADDCY, 8'h00, 8'h00);
    run_drain(40);

    // Response backpressure with a competing request waiting.
    do_reset();
    hold_left = 5;
    push_op(0, C_SUB, 8'h10, 8'h20);
    push_op(1, C_XOR, 8'h5A, 8'hA5);
    run_drain(80);
    hold_left = 0;

    // Reset while an op is in flight drops it and clears the saved carry.
    do_reset();
    push_op(1, C_ADD, 8'hFF, 8'h01);
    run_drain(40);
    push_op(1, C_ADD, 8'hFF, 8'h02);
    applyStimulus();
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc[1] && n < 50);
    if (n >= 50) drv_timeouts++;
    step();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    push_op(1, C_ADDCY, 8'h00, 8'h00);
    run_drain(40);

    // Randomised traffic with random response stalls.
    do_reset();
    rand_rsp = 1'b1;
    for (int k = 0; k < 15; k++) begin
      push_op(0, codes[$urandom_range(0, 6)], 8'($urandom), 8'($urandom));
      push_op(1, codes[$urandom_range(0, 6)], 8'($urandom), 8'($urandom));
    end
    run_drain(1000);
    rand_rsp = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, mism);
    $finish;
  end

endmodule
